// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-ported RAM between the instruction-fetch path and the
// data path. One RAM transaction runs at a time; the losing requester is
// held with its wait signal. A completed access shows up as its wait
// signal dropping low for exactly one cycle.
//
// Optional feature (compile-time macro ARB_FAIRNESS_EN):
//   When defined, a saturating 4-bit counter tracks data completions that
//   occur while an instruction fetch is pending. Once it reaches
//   STARVE_LIMIT, the next arbitration in IDLE goes to the instruction
//   path. When undefined, data always has priority and no counter exists.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [1:0] RS_ACCESS = 2'd2;

    // Limit clamped into the legal 1..15 range so a bad override cannot
    // disable or overflow the starvation check.
    localparam logic [3:0] LIMIT = (STARVE_LIMIT > 32'd15) ? 4'd15 :
                                   (STARVE_LIMIT < 32'd1)  ? 4'd1  :
                                   4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IGRANT = 2'd1,
        ST_DGRANT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic dreq_s;
    logic starve_s;

    assign dreq_s = dREN | dWEN;

    // Read data is simply forwarded; it is meaningful only on completion.
    assign iload = ramload;
    assign dload = ramload;

`ifdef ARB_FAIRNESS_EN
    logic [3:0] dcount_q;
    logic [3:0] dcount_d;
    logic       icomp_s;
    logic       dcomp_s;

    assign icomp_s  = (state_q == ST_IGRANT) && iREN && (ramstate == RS_ACCESS);
    assign dcomp_s  = (state_q == ST_DGRANT) && dreq_s && (ramstate == RS_ACCESS);
    assign starve_s = (dcount_q >= LIMIT);

    // Starvation counter: counts data completions while a fetch waits.
    always_comb begin
        dcount_d = dcount_q;
        if (!iREN || icomp_s) begin
            dcount_d = 4'd0;
        end else if (dcomp_s && (dcount_q != 4'd15)) begin
            dcount_d = dcount_q + 4'd1;
        end else begin
            dcount_d = dcount_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dcount_q <= 4'd0;
        end else begin
            dcount_q <= dcount_d;
        end
    end
`else
    // Without a counter the count is pinned at zero, which never reaches
    // the (always >= 1) limit, so data keeps strict priority.
    assign starve_s = (4'd0 >= LIMIT);
`endif

    // Arbitration, RAM drive and wait generation for the current grant.
    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = iREN;
        dwait    = dreq_s;
        case (state_q)
            ST_IDLE: begin
                if (iREN && starve_s) begin
                    state_d = ST_IGRANT;
                end else if (dreq_s) begin
                    state_d = ST_DGRANT;
                end else if (iREN) begin
                    state_d = ST_IGRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq_s) begin
                    // Requester walked away: drop enables, no completion.
                    dwait   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // A write wins when both read and write are requested.
                    ramWEN = dWEN;
                    ramREN = ~dWEN;
                    if (ramstate == RS_ACCESS) begin
                        dwait   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // FREE, BUSY and ERROR all hold; ERROR retries forever.
                        dwait   = 1'b1;
                        state_d = ST_DGRANT;
                    end
                end
            end
            ST_IGRANT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    iwait   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RS_ACCESS) begin
                        iwait   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        iwait   = 1'b1;
                        state_d = ST_IGRANT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant state register; reset forces IDLE and drops the RAM enables at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
